// File: rtl/add_pipe_if.sv
// add_pipe_if: operand/result bus for add_pipe.
// Carries the input handshake (A, B, in_valid, in_ready, acc_en, acc_clr)
// and the output handshake (C, carry, out_valid, out_ready) plus the
// completed-transfer counter. The slave modport is the adder's view and the
// master modport is the stimulus/checker view.
interface add_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic             in_ready;
    logic             acc_en;
    logic             acc_clr;
    logic [WIDTH-1:0] C;
    logic             carry;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;

    modport slave (
        input  A, B, in_valid, acc_en, acc_clr, out_ready,
        output in_ready, C, carry, out_valid, count
    );

    modport master (
        output A, B, in_valid, acc_en, acc_clr, out_ready,
        input  in_ready, C, carry, out_valid, count
    );
endinterface

// File: rtl/add_pipe.sv
// add_pipe: registered multi-stage unsigned adder with valid/ready flow
// control on both sides, an accumulate mode and a wrapping count of
// completed output transfers.
//
// Stage 0 computes the (WIDTH+1)-bit sum; later stages only move it along.
// Each stage may load whenever it is empty or its downstream neighbour is
// loading, so a full pipe with out_ready=1 still accepts a new input every
// cycle.
//
// Build option: define ADD_PIPE_SATURATE_EN to clamp overflowing sums to all
// ones (carry still 1); the accumulator then saturates as well and stays
// there until acc_clr. Without it, sums wrap modulo 2^WIDTH.
module add_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    add_pipe_if.slave  bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("add_pipe: STAGES must be in 1..4");
        end
    endgenerate

    // Pipeline state: valid bit and {carry, C} per stage.
    logic [STAGES-1:0] r_valid;
    logic [WIDTH:0]    r_data [STAGES];
    logic [WIDTH-1:0]  r_acc;
    logic [CNT_W-1:0]  r_count;

    logic [STAGES:0]   w_ready;
    logic [WIDTH-1:0]  w_acc_base;
    logic [WIDTH:0]    w_raw_sum;
    logic [WIDTH:0]    w_sum;
    logic              w_in_xfer;
    logic              w_out_xfer;

    // Overflow policy applied to the raw stage-0 sum.
    function automatic logic [WIDTH:0] apply_overflow(input logic [WIDTH:0] s);
`ifdef ADD_PIPE_SATURATE_EN
        if (s[WIDTH]) begin
            return {1'b1, ALL_ONES};
        end else begin
            return s;
        end
`else
        return s;
`endif
    endfunction

    // Back-to-front ready chain: a stage can load if it is empty or the next one loads.
    always_comb begin
        logic w_chain;
        w_ready          = '0;
        w_chain          = bus.out_ready;
        w_ready[STAGES]  = w_chain;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_chain    = ~r_valid[i] | w_chain;
            w_ready[i] = w_chain;
        end
    end

    // Stage-0 adder: plain A+B, or accumulator (optionally cleared first) plus A.
    always_comb begin
        if (bus.acc_clr) begin
            w_acc_base = '0;
        end else begin
            w_acc_base = r_acc;
        end
        if (bus.acc_en) begin
            w_raw_sum = {1'b0, w_acc_base} + {1'b0, bus.A};
        end else begin
            w_raw_sum = {1'b0, bus.A} + {1'b0, bus.B};
        end
        w_sum = apply_overflow(w_raw_sum);
    end

    assign w_in_xfer  = bus.in_valid & w_ready[0];
    assign w_out_xfer = r_valid[STAGES-1] & bus.out_ready;

    // Pipeline registers: load on ready, data only captured when upstream is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_ready[0]) begin
                r_valid[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    r_data[0] <= w_sum;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_ready[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
        end
    end

    // Accumulator: changes only on an accepted input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_in_xfer) begin
            if (bus.acc_en) begin
                r_acc <= w_sum[WIDTH-1:0];
            end else if (bus.acc_clr) begin
                r_acc <= '0;
            end
        end
    end

    // Completed-output counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_out_xfer) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // in_ready is held low while reset is asserted.
    assign bus.in_ready  = w_ready[0] & ~rst;
    assign bus.C         = r_data[STAGES-1][WIDTH-1:0];
    assign bus.carry     = r_data[STAGES-1][WIDTH];
    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.count     = r_count;

endmodule
